// File: rtl/capture_mem_ctrl.sv
// capture_mem_ctrl: sequences one acquisition into a single-port sample RAM
// (pre-trigger fill, trigger wait, post-trigger fill) and then serves
// trigger-aligned readout from the same RAM port.
//
// Build option: define TRIG_EDGE_EN to make the trigger rising-edge sensitive
// (trig registered internally). Without it the trigger is level sensitive.
module capture_mem_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              arm,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              trig,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_write,
    output logic              mem_clk_en
);

    // Counter is one bit wider than an address so it can hold DEPTH itself.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_inc_s;
    logic [CNT_W-1:0]    post_target_s;
    logic [ADDR_W-1:0]   pre_len_r;
    logic [ADDR_W-1:0]   start_addr_r;
    logic                busy_r;
    logic                done_r;
    logic                trig_cond_s;
    logic                capturing_s;
    logic                wr_accept_s;
    logic                trig_fire_s;
    logic                rd_accept_s;
    logic [ADDR_W-1:0]   mem_address_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                mem_cs_r;
    logic                mem_write_r;
    logic                rd_pend_r;
    logic                rd_valid_r;

`ifdef TRIG_EDGE_EN
    logic                trig_q_r;

    // Previous-cycle trig, tracked every cycle so an edge during a sample gap is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q_r <= 1'b0;
        end else begin
            trig_q_r <= trig;
        end
    end

    assign trig_cond_s = trig & ~trig_q_r;
`else
    assign trig_cond_s = trig;
`endif

    assign cnt_inc_s     = cnt_r + CNT_ONE;
    // Samples still to take after the trigger, including the trigger sample.
    assign post_target_s = DEPTH_C - {1'b0, pre_len_r};

    // Accept/trigger/read qualification; arm always wins over same-cycle traffic.
    always_comb begin
        capturing_s = 1'b0;
        case (state_r)
            ST_PRE, ST_ARMED, ST_POST: capturing_s = 1'b1;
            default:                   capturing_s = 1'b0;
        endcase
        wr_accept_s = sample_valid & ~arm & capturing_s;
        trig_fire_s = wr_accept_s & trig_cond_s & (state_r == ST_ARMED);
        rd_accept_s = rd_en & ~arm & (state_r == ST_DONE);
    end

    // Next-state decode of the acquisition sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = ST_IDLE;
            ST_PRE: begin
                if (wr_accept_s && (cnt_inc_s == {1'b0, pre_len_r})) begin
                    next_state_s = ST_ARMED;
                end else begin
                    next_state_s = ST_PRE;
                end
            end
            ST_ARMED: begin
                if (trig_fire_s) begin
                    if (post_target_s == CNT_ONE) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_POST;
                    end
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_POST: begin
                if (wr_accept_s && (cnt_inc_s == post_target_s)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_POST;
                end
            end
            ST_DONE: next_state_s = ST_DONE;
            default: next_state_s = ST_IDLE;
        endcase
        if (arm) begin
            if (pre_len == {ADDR_W{1'b0}}) begin
                next_state_s = ST_ARMED;
            end else begin
                next_state_s = ST_PRE;
            end
        end else begin
            next_state_s = next_state_s;
        end
    end

    // FSM state, write pointer, sample counter and record origin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            pre_len_r    <= {ADDR_W{1'b0}};
            start_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_PRE) || (next_state_s == ST_ARMED) ||
                       (next_state_s == ST_POST);
            done_r  <= (next_state_s == ST_DONE);
            if (arm) begin
                wr_ptr_r  <= {ADDR_W{1'b0}};
                cnt_r     <= {CNT_W{1'b0}};
                pre_len_r <= pre_len;
            end else if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (trig_fire_s) begin
                    cnt_r        <= CNT_ONE;
                    start_addr_r <= wr_ptr_r - pre_len_r;
                end else begin
                    cnt_r <= cnt_inc_s;
                end
            end
        end
    end

    // Registered RAM port: capture writes, or trigger-aligned reads once DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address_r <= {ADDR_W{1'b0}};
            mem_wdata_r   <= {DATA_W{1'b0}};
            mem_cs_r      <= 1'b0;
            mem_write_r   <= 1'b0;
        end else if (wr_accept_s) begin
            mem_address_r <= wr_ptr_r;
            mem_wdata_r   <= sample_in;
            mem_cs_r      <= 1'b1;
            mem_write_r   <= 1'b1;
        end else if (rd_accept_s) begin
            mem_address_r <= start_addr_r + rd_idx;
            mem_cs_r      <= 1'b1;
            mem_write_r   <= 1'b0;
        end else begin
            mem_cs_r    <= 1'b0;
            mem_write_r <= 1'b0;
        end
    end

    // Read return pipeline; arm does not cancel reads already issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r  <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_pend_r  <= rd_accept_s;
            rd_valid_r <= rd_pend_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_address = mem_address_r;
    assign mem_wdata   = mem_wdata_r;
    assign mem_cs      = mem_cs_r;
    assign mem_write   = mem_write_r;
    assign mem_clk_en  = 1'b1;
    assign rd_valid    = rd_valid_r;
    // RAM read data is already registered inside the RAM; it is forwarded in the
    // cycle rd_valid is high so the result lands two cycles after rd_en.
    assign rd_data     = rd_valid_r ? mem_rdata : {DATA_W{1'b0}};

endmodule
